// File: rtl/rca_pipe_addsub.sv
// rca_pipe_addsub: WIDTH-bit add/subtract built from pipelined CHUNK-bit ripple segments with valid/ready flow control.
// Optional RCA_PIPE_SAT_EN clamps the sum to signed max/min on overflow.
module rca_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int S = WIDTH / CHUNK;
  logic [S-1:0] v, c, vi, ci;
  logic [WIDTH-1:0] x [S], y [S], r [S], xi [S], yi [S], ri [S], nr [S];
  logic [CHUNK:0] t [S];
  logic [WIDTH-1:0] sum_n;
  logic advance, ovf_n;
  assign advance   = ~(out_valid & ~out_ready);
  assign in_ready  = advance;
  assign out_valid = v[S-1];
  assign sum       = r[S-1];
  assign cout      = c[S-1];
  for (genvar k = 0; k < S; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign vi[k] = in_valid;
      assign xi[k] = a;
      assign yi[k] = sub ? ~b : b;
      assign ci[k] = sub | cin;
      assign ri[k] = '0;
    end else begin : g_next
      assign vi[k] = v[k-1];
      assign xi[k] = x[k-1];
      assign yi[k] = y[k-1];
      assign ci[k] = c[k-1];
      assign ri[k] = r[k-1];
    end
    assign t[k]  = {1'b0, xi[k][k*CHUNK +: CHUNK]} + {1'b0, yi[k][k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, ci[k]};
    // result chunks above k are still zero, so OR-ing in the new chunk is enough
    assign nr[k] = ri[k] | (WIDTH'(t[k][CHUNK-1:0]) << (k * CHUNK));
  end
  // carry into the MSB is recovered from the MSB sum bit and operand MSBs
  assign ovf_n = t[S-1][CHUNK] ^ t[S-1][CHUNK-1] ^ xi[S-1][WIDTH-1] ^ yi[S-1][WIDTH-1];
`ifdef RCA_PIPE_SAT_EN
  assign sum_n = ovf_n ? {xi[S-1][WIDTH-1], {(WIDTH-1){~xi[S-1][WIDTH-1]}}} : nr[S-1];
`else
  assign sum_n = nr[S-1];
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v   <= '0;
      c   <= '0;
      ovf <= 1'b0;
      for (int k = 0; k < S; k++) begin
        x[k] <= '0;
        y[k] <= '0;
        r[k] <= '0;
      end
    end else if (advance) begin
      v   <= vi;
      ovf <= ovf_n;
      for (int k = 0; k < S; k++) begin
        c[k] <= t[k][CHUNK];
        x[k] <= xi[k];
        y[k] <= yi[k];
        r[k] <= (k == S - 1) ? sum_n : nr[k];
      end
    end
  end
endmodule

// File: tb/tb_rca_pipe_addsub.sv
// tb_rca_pipe_addsub: scoreboard bench for rca_pipe_addsub (WIDTH=16, CHUNK=4).
// Honours RCA_PIPE_SAT_EN in its reference model.
module tb_rca_pipe_addsub;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, cin = 0, sub = 0;
  logic out_valid, out_ready = 1, cout, ovf;
  logic [15:0] a = 0, b = 0, sum;
  typedef struct packed { logic [15:0] s; logic c; logic o; } exp_t;
  exp_t q [$];
  int n_cmp = 0, n_bad = 0, n_acc = 0;

  rca_pipe_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [15:0] x, logic [15:0] y, logic ci, logic s);
    exp_t e;
    int ux = x, uy = y, sx = $signed(x), sy = $signed(y), res, sres;
    if (s) begin
      res = ux - uy; sres = sx - sy; e.c = ux >= uy;
    end else begin
      res = ux + uy + int'(ci); sres = sx + sy + int'(ci); e.c = res > 65535;
    end
    e.s = res[15:0];
    e.o = sres > 32767 || sres < -32768;
`ifdef RCA_PIPE_SAT_EN
    if (e.o) e.s = sres > 0 ? 16'h7fff : 16'h8000;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // scoreboard monitor: output checked against queue head every valid cycle, popped on transfer
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_out", 32'(out_valid), 0);
        else begin
          chk("result", {14'd0, sum, cout, ovf}, {14'd0, q[0]});
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts);
    int n = 0;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (n == 200) chk("accept_timeout", 1, 0);
    tick();
    in_valid = 0;
  endtask

  task automatic expect_out(input string name, input logic [15:0] s, input logic c, input logic o);
    int n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (n == 50) chk({name, "_timeout"}, 1, 0);
    else chk(name, {14'd0, sum, cout, ovf}, {14'd0, s, c, o});
    tick();
  endtask

  function automatic logic [15:0] pick();
    int k = $urandom_range(0, 9);
    return k == 0 ? 16'h0000 : k == 1 ? 16'hffff : k == 2 ? 16'h7fff : k == 3 ? 16'h8000 : 16'($urandom);
  endfunction

  initial begin
    int n, cyc, base;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1;
    tick();
    // latency: accepted on the edge ending beat(), result visible after the 4th edge counting that one
    beat(16'h1234, 16'h0fff, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("lat_valid_%0d", i), 32'(out_valid), 32'(i == 4));
      if (i < 4) tick();
    end
    chk("first_result", {14'd0, sum, cout, ovf}, {14'd0, 16'h2234, 1'b0, 1'b0});
    tick();
    chk("one_cycle_valid", 32'(out_valid), 0);
    beat(16'hffff, 16'h0001, 0, 0);
    beat(16'h0005, 16'h0007, 0, 1);
    expect_out("wrap_add", 16'h0000, 1, 0);
    chk("back_to_back", 32'(out_valid), 1);
    expect_out("sub_neg", 16'hfffe, 0, 0);
    beat(16'h7fff, 16'h0001, 0, 0);
    beat(16'h8000, 16'h0001, 0, 1);
`ifdef RCA_PIPE_SAT_EN
    expect_out("ovf_pos", 16'h7fff, 0, 1);
    expect_out("ovf_neg", 16'h8000, 1, 1);
`else
    expect_out("ovf_pos", 16'h8000, 0, 1);
    expect_out("ovf_neg", 16'h7fff, 1, 1);
`endif
    // backpressure: six beats streamed while the first result is held for three cycles
    fork
      for (int i = 0; i < 6; i++) beat(16'(i * 16'h1111), 16'(16'h0f0f + i), 1'(i), 1'(i % 2));
      begin
        n = 0;
        @(posedge clk); #1;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
          #1;
          chk($sformatf("stall_in_ready_%0d", i), 32'(in_ready), 0);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    n = 0;
    while (q.size() > 0 && n < 100) begin tick(); n++; end
    chk("bp_drain", q.size(), 0);
    // reset with beats in flight: nothing stale may appear
    beat(16'h1111, 16'h2222, 0, 0);
    beat(16'h3333, 16'h4444, 1, 0);
    beat(16'h5555, 16'h0001, 0, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("post_rst_idle_%0d", i), 32'(out_valid), 0);
      tick();
    end
    beat(16'h00ff, 16'h0001, 0, 0);
    n = 1;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("post_rst_latency", n, 4);
    chk("post_rst_sum", 32'(sum), 32'h0100);
    tick();
    // random traffic with random backpressure
    base = n_acc;
    cyc = 0;
    while (n_acc - base < 10000 && cyc < 60000) begin
      out_ready = $urandom_range(0, 9) < 7;
      in_valid = $urandom_range(0, 9) < 7;
      a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
      tick();
      cyc++;
    end
    chk("random_beats", 32'(n_acc - base >= 10000), 1);
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while (q.size() > 0 && n < 100) begin tick(); n++; end
    chk("final_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
